cpu_datapath: RTL and testbench

- Execution side of the CPU control interface: owns the sequence counter that generates the one-hot timing vector T[7:0] consumed by the control unit.
- Executes the control unit's register load/clear/increment strobes, bus select, memory strobes and ALU commands.
- Holds AR, PC, DR, AC, IR, TR, the ALU result register and the carry flag.
- Fronts an external synchronous memory through a ready handshake that stalls the sequence.

---
 rtl/cpu_datapath.sv | 187 ++++++++++++++++++
 tb/tb_cpu_datapath.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_datapath.sv
// Execution datapath behind the CPU control unit: one-hot timing sequence,
// register file, ALU with carry flag, and a ready-stalled memory front end.
module cpu_datapath #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8,
   localparam int unsigned T_W   = 8,
   localparam int unsigned SEL_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [T_W-1:0]    T,
   output logic [DATA_W-1:0] IR,
   input  logic              load_AR,
   input  logic              load_PC,
   input  logic              load_DR,
   input  logic              load_AC,
   input  logic              load_IR,
   input  logic              load_TR,
   input  logic              clear_AR,
   input  logic              clear_PC,
   input  logic              clear_DR,
   input  logic              clear_AC,
   input  logic              clear_TR,
   input  logic              inc_AR,
   input  logic              inc_PC,
   input  logic              inc_DR,
   input  logic              inc_AC,
   input  logic              inc_TR,
   input  logic              seq_counter_RESET,
   input  logic              memory_read,
   input  logic              memory_write,
   input  logic [SEL_W-1:0]  bus_selectors,
   input  logic              alu_enable,
   input  logic [SEL_W-1:0]  alu_mode,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] AR,
   output logic [ADDR_W-1:0] PC,
   output logic [DATA_W-1:0] DR,
   output logic [DATA_W-1:0] AC,
   output logic [DATA_W-1:0] TR,
   output logic              E
);

   typedef enum logic [SEL_W-1:0] {
      BUS_ZERO = 3'd0, BUS_AR = 3'd1, BUS_PC = 3'd2, BUS_DR = 3'd3,
      BUS_AC   = 3'd4, BUS_IR = 3'd5, BUS_TR = 3'd6, BUS_MEM = 3'd7
   } bus_sel_e;

   typedef enum logic [SEL_W-1:0] {
      ALU_AND = 3'd0, ALU_ADD = 3'd1, ALU_SUB = 3'd2, ALU_OR    = 3'd3,
      ALU_XOR = 3'd4, ALU_PSA = 3'd5, ALU_NOT = 3'd6, ALU_PSB   = 3'd7
   } alu_mode_e;

   logic [T_W-1:0]    t_q, t_d;
   logic [ADDR_W-1:0] ar_q, ar_d, pc_q, pc_d;
   logic [DATA_W-1:0] dr_q, dr_d, ac_q, ac_d, ir_q, ir_d, tr_q, tr_d;
   logic [DATA_W-1:0] alu_q, alu_d;
   logic              e_q, e_d;

   logic [DATA_W-1:0] bus_c;
   logic              stall_c;
   logic [DATA_W:0]   sum_c, diff_c;

   // Shared bus source select; address registers are zero-extended onto it.
   always_comb begin
      bus_c = '0;
      case (bus_sel_e'(bus_selectors))
         BUS_ZERO: bus_c = '0;
         BUS_AR:   bus_c = DATA_W'(ar_q);
         BUS_PC:   bus_c = DATA_W'(pc_q);
         BUS_DR:   bus_c = dr_q;
         BUS_AC:   bus_c = ac_q;
         BUS_IR:   bus_c = ir_q;
         BUS_TR:   bus_c = tr_q;
         BUS_MEM:  bus_c = mem_rdata;
         default:  bus_c = '0;
      endcase
   end

   assign stall_c = (memory_read | memory_write) & ~mem_ready;
   assign sum_c   = {1'b0, ac_q} + {1'b0, dr_q};
   assign diff_c  = {1'b0, ac_q} - {1'b0, dr_q};

   // ALU result and carry; E only changes on ADD/SUB.
   always_comb begin
      alu_d = alu_q;
      e_d   = e_q;
      if (alu_enable && !stall_c) begin
         case (alu_mode_e'(alu_mode))
            ALU_AND: alu_d = ac_q & dr_q;
            ALU_ADD: begin
               alu_d = sum_c[DATA_W-1:0];
               e_d   = sum_c[DATA_W];
            end
            ALU_SUB: begin
               alu_d = diff_c[DATA_W-1:0];
               e_d   = diff_c[DATA_W];
            end
            ALU_OR:  alu_d = ac_q | dr_q;
            ALU_XOR: alu_d = ac_q ^ dr_q;
            ALU_PSA: alu_d = ac_q;
            ALU_NOT: alu_d = ~ac_q;
            ALU_PSB: alu_d = dr_q;
            default: alu_d = alu_q;
         endcase
      end
   end

   // Sequence and register updates; everything freezes while memory stalls.
   always_comb begin
      t_d  = t_q;
      ar_d = ar_q;
      pc_d = pc_q;
      dr_d = dr_q;
      ac_d = ac_q;
      ir_d = ir_q;
      tr_d = tr_q;
      if (!stall_c) begin
         t_d = seq_counter_RESET ? T_W'(1) : {t_q[T_W-2:0], t_q[T_W-1]};

         if (clear_AR)     ar_d = '0;
         else if (load_AR) ar_d = ADDR_W'(bus_c);
         else if (inc_AR)  ar_d = ar_q + ADDR_W'(1);

         if (clear_PC)     pc_d = '0;
         else if (load_PC) pc_d = ADDR_W'(bus_c);
         else if (inc_PC)  pc_d = pc_q + ADDR_W'(1);

         if (clear_DR)     dr_d = '0;
         else if (load_DR) dr_d = bus_c;
         else if (inc_DR)  dr_d = dr_q + DATA_W'(1);

         if (clear_AC)     ac_d = '0;
         else if (load_AC) ac_d = alu_q;
         else if (inc_AC)  ac_d = ac_q + DATA_W'(1);

         if (load_IR)      ir_d = bus_c;

         if (clear_TR)     tr_d = '0;
         else if (load_TR) tr_d = bus_c;
         else if (inc_TR)  tr_d = tr_q + DATA_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         t_q   <= T_W'(1);
         ar_q  <= '0;
         pc_q  <= '0;
         dr_q  <= '0;
         ac_q  <= '0;
         ir_q  <= '0;
         tr_q  <= '0;
         alu_q <= '0;
         e_q   <= 1'b0;
      end else begin
         t_q   <= t_d;
         ar_q  <= ar_d;
         pc_q  <= pc_d;
         dr_q  <= dr_d;
         ac_q  <= ac_d;
         ir_q  <= ir_d;
         tr_q  <= tr_d;
         alu_q <= alu_d;
         e_q   <= e_d;
      end
   end

   assign T         = t_q;
   assign IR        = ir_q;
   assign AR        = ar_q;
   assign PC        = pc_q;
   assign DR        = dr_q;
   assign AC        = ac_q;
   assign TR        = tr_q;
   assign E         = e_q;
   assign mem_addr  = ar_q;
   assign mem_wdata = bus_c;
   assign mem_rd    = memory_read;
   assign mem_wr    = memory_write;

endmodule

// File: tb/tb_cpu_datapath.sv
// Scoreboard bench for cpu_datapath: directed scenarios plus random strobes,
// checked against an arithmetic reference model of the register machine.
module tb_cpu_datapath;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [7:0]        T;
   logic [DATA_W-1:0] IR;
   logic load_AR, load_PC, load_DR, load_AC, load_IR, load_TR;
   logic clear_AR, clear_PC, clear_DR, clear_AC, clear_TR;
   logic inc_AR, inc_PC, inc_DR, inc_AC, inc_TR;
   logic seq_counter_RESET, memory_read, memory_write;
   logic [2:0]        bus_selectors;
   logic              alu_enable;
   logic [2:0]        alu_mode;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_rd, mem_wr;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   logic [ADDR_W-1:0] AR, PC;
   logic [DATA_W-1:0] DR, AC, TR;
   logic              E;

   cpu_datapath #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .T(T), .IR(IR),
      .load_AR(load_AR), .load_PC(load_PC), .load_DR(load_DR),
      .load_AC(load_AC), .load_IR(load_IR), .load_TR(load_TR),
      .clear_AR(clear_AR), .clear_PC(clear_PC), .clear_DR(clear_DR),
      .clear_AC(clear_AC), .clear_TR(clear_TR),
      .inc_AR(inc_AR), .inc_PC(inc_PC), .inc_DR(inc_DR),
      .inc_AC(inc_AC), .inc_TR(inc_TR),
      .seq_counter_RESET(seq_counter_RESET),
      .memory_read(memory_read), .memory_write(memory_write),
      .bus_selectors(bus_selectors), .alu_enable(alu_enable),
      .alu_mode(alu_mode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .AR(AR), .PC(PC), .DR(DR), .AC(AC),
      .TR(TR), .E(E)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit chk;
      int t, ar, pc, dr, ac, ir, tr, e, maddr, wdata, rd, wr;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference machine state: plain integers, wrapping done with modulo.
   int m_sc, m_ar, m_pc, m_dr, m_ac, m_ir, m_tr, m_alu, m_e;
   bit m_valid = 1'b0;

   task automatic cmp(input string name, input logic [31:0] act, input int exp);
      total++;
      if (act !== 32'(exp)) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int bus_val();
      case (int'(bus_selectors))
         1: return m_ar;
         2: return m_pc;
         3: return m_dr;
         4: return m_ac;
         5: return m_ir;
         6: return m_tr;
         7: return int'(mem_rdata);
         default: return 0;
      endcase
   endfunction

   task automatic model_update();
      int b, s;
      int n_ar, n_pc, n_dr, n_ac, n_ir, n_tr, n_alu, n_e, n_sc;
      b = bus_val();
      if (rst_n !== 1'b1) begin
         m_sc = 0; m_ar = 0; m_pc = 0; m_dr = 0; m_ac = 0;
         m_ir = 0; m_tr = 0; m_alu = 0; m_e = 0;
         m_valid = 1'b1;
      end else if (!((memory_read || memory_write) && !mem_ready)) begin
         n_ar = clear_AR ? 0 : load_AR ? b : inc_AR ? (m_ar + 1) % 256 : m_ar;
         n_pc = clear_PC ? 0 : load_PC ? b : inc_PC ? (m_pc + 1) % 256 : m_pc;
         n_dr = clear_DR ? 0 : load_DR ? b : inc_DR ? (m_dr + 1) % 256 : m_dr;
         n_ac = clear_AC ? 0 : load_AC ? m_alu : inc_AC ? (m_ac + 1) % 256 : m_ac;
         n_tr = clear_TR ? 0 : load_TR ? b : inc_TR ? (m_tr + 1) % 256 : m_tr;
         n_ir = load_IR ? b : m_ir;
         n_alu = m_alu;
         n_e   = m_e;
         if (alu_enable) begin
            case (int'(alu_mode))
               0: n_alu = m_ac & m_dr;
               1: begin s = m_ac + m_dr; n_alu = s % 256; n_e = (s > 255) ? 1 : 0; end
               2: begin n_alu = (m_ac - m_dr + 256) % 256; n_e = (m_ac < m_dr) ? 1 : 0; end
               3: n_alu = m_ac | m_dr;
               4: n_alu = m_ac ^ m_dr;
               5: n_alu = m_ac;
               6: n_alu = 255 - m_ac;
               default: n_alu = m_dr;
            endcase
         end
         n_sc = seq_counter_RESET ? 0 : (m_sc + 1) % 8;
         m_ar = n_ar; m_pc = n_pc; m_dr = n_dr; m_ac = n_ac; m_ir = n_ir;
         m_tr = n_tr; m_alu = n_alu; m_e = n_e; m_sc = n_sc;
      end
   endtask

   // Issue one cycle: push what the DUT must show during it, then advance.
   task automatic step();
      exp_t x;
      x.chk   = m_valid;
      x.t     = 1 << m_sc;
      x.ar    = m_ar; x.pc = m_pc; x.dr = m_dr; x.ac = m_ac;
      x.ir    = m_ir; x.tr = m_tr; x.e  = m_e;
      x.maddr = m_ar;
      x.wdata = bus_val();
      x.rd    = int'(memory_read);
      x.wr    = int'(memory_write);
      q.push_back(x);
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic set_strobes(input logic v);
      load_AR = v; load_PC = v; load_DR = v; load_AC = v; load_IR = v; load_TR = v;
      clear_AR = v; clear_PC = v; clear_DR = v; clear_AC = v; clear_TR = v;
      inc_AR = v; inc_PC = v; inc_DR = v; inc_AC = v; inc_TR = v;
      seq_counter_RESET = v; memory_read = v; memory_write = v; alu_enable = v;
   endtask

   task automatic clr_in();
      set_strobes(1'b0);
      rst_n = 1'b1; mem_ready = 1'b1; mem_rdata = '0;
      bus_selectors = 3'd0; alu_mode = 3'd0;
   endtask

   task automatic set_dr(input int v);
      clr_in(); bus_selectors = 3'd7; mem_rdata = 8'(v); load_DR = 1'b1; step();
   endtask

   task automatic set_ac(input int v);
      set_dr(v);
      clr_in(); alu_enable = 1'b1; alu_mode = 3'd7; step();
      clr_in(); load_AC = 1'b1; step();
   endtask

   task automatic alu_to_ac(input int mode);
      clr_in(); alu_enable = 1'b1; alu_mode = 3'(mode); step();
      clr_in(); load_AC = 1'b1; step();
   endtask

   // Monitor: compares the DUT against the oldest queued expectation.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            x = q.pop_front();
            if (x.chk) begin
               cmp("T", 32'(T), x.t);
               cmp("AR", 32'(AR), x.ar);
               cmp("PC", 32'(PC), x.pc);
               cmp("DR", 32'(DR), x.dr);
               cmp("AC", 32'(AC), x.ac);
               cmp("IR", 32'(IR), x.ir);
               cmp("TR", 32'(TR), x.tr);
               cmp("E", 32'(E), x.e);
               cmp("mem_addr", 32'(mem_addr), x.maddr);
               cmp("mem_wdata", 32'(mem_wdata), x.wdata);
               cmp("mem_rd", 32'(mem_rd), x.rd);
               cmp("mem_wr", 32'(mem_wr), x.wr);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
      $fatal(1);
   end

   initial begin
      clr_in();
      @(posedge clk);
      #1;

      // Reset with every strobe high and a stalled access pending.
      set_strobes(1'b1); mem_ready = 1'b0; bus_selectors = 3'd7;
      mem_rdata = 8'hC3; alu_mode = 3'd1; rst_n = 1'b0;
      step(); step();
      clr_in();
      repeat (9) step();

      // Fetch with three wait states.
      clr_in(); seq_counter_RESET = 1'b1; step();
      clr_in(); bus_selectors = 3'd7; mem_rdata = 8'h10; load_PC = 1'b1; step();
      clr_in(); bus_selectors = 3'd2; load_AR = 1'b1; step();
      clr_in(); bus_selectors = 3'd7; memory_read = 1'b1; load_IR = 1'b1;
      inc_PC = 1'b1; mem_ready = 1'b0; mem_rdata = 8'h5A;
      repeat (3) step();
      mem_ready = 1'b1; mem_rdata = 8'hA5; step();
      clr_in(); step();

      // ALU add with carry, subtract with borrow, E hold on logic op.
      set_ac(8'hF0); set_dr(8'h20); alu_to_ac(1);
      set_ac(8'h05); set_dr(8'h06); alu_to_ac(2);
      alu_to_ac(0);

      // Clear beats load and inc; TR wraps.
      clr_in(); bus_selectors = 3'd7; mem_rdata = 8'h33; load_PC = 1'b1; step();
      clr_in(); clear_PC = 1'b1; load_PC = 1'b1; inc_PC = 1'b1;
      bus_selectors = 3'd7; mem_rdata = 8'h44; step();
      clr_in(); bus_selectors = 3'd7; mem_rdata = 8'hFF; load_TR = 1'b1; step();
      clr_in(); inc_TR = 1'b1; step();

      // Write handshake with two wait states.
      set_ac(8'h3C);
      clr_in(); bus_selectors = 3'd7; mem_rdata = 8'h40; load_AR = 1'b1; step();
      clr_in(); bus_selectors = 3'd4; memory_write = 1'b1; seq_counter_RESET = 1'b1;
      mem_ready = 1'b0; step(); step();
      mem_ready = 1'b1; step();
      clr_in(); step();

      // Reset during a stalled read.
      clr_in(); bus_selectors = 3'd7; memory_read = 1'b1; load_IR = 1'b1;
      mem_ready = 1'b0; mem_rdata = 8'h77; step();
      rst_n = 1'b0; step();
      clr_in(); step();

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         load_AR  = ($urandom_range(0, 3) == 0); load_PC = ($urandom_range(0, 3) == 0);
         load_DR  = ($urandom_range(0, 3) == 0); load_AC = ($urandom_range(0, 3) == 0);
         load_IR  = ($urandom_range(0, 3) == 0); load_TR = ($urandom_range(0, 3) == 0);
         clear_AR = ($urandom_range(0, 7) == 0); clear_PC = ($urandom_range(0, 7) == 0);
         clear_DR = ($urandom_range(0, 7) == 0); clear_AC = ($urandom_range(0, 7) == 0);
         clear_TR = ($urandom_range(0, 7) == 0);
         inc_AR   = ($urandom_range(0, 3) == 0); inc_PC = ($urandom_range(0, 3) == 0);
         inc_DR   = ($urandom_range(0, 3) == 0); inc_AC = ($urandom_range(0, 3) == 0);
         inc_TR   = ($urandom_range(0, 3) == 0);
         seq_counter_RESET = ($urandom_range(0, 7) == 0);
         memory_read  = ($urandom_range(0, 3) == 0);
         memory_write = ($urandom_range(0, 5) == 0);
         mem_ready    = ($urandom_range(0, 2) != 0);
         alu_enable   = ($urandom_range(0, 1) == 0);
         alu_mode      = 3'($urandom_range(0, 7));
         bus_selectors = 3'($urandom_range(0, 7));
         mem_rdata     = 8'($urandom_range(0, 255));
         rst_n         = ($urandom_range(0, 59) != 0);
         step();
      end

      clr_in(); step(); step();
      repeat (3) @(negedge clk);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
